partial_force_acc_ctrl: RTL

// - Schedules neighbour-force fragments from NUM_FILTERS filter lanes into the shared partial-force

---
 rtl/partial_force_acc_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/partial_force_acc_ctrl.sv
// rtl/partial_force_acc_ctrl.sv - round-robin scheduler feeding lane fragments into the partial-force accumulator
//
// Optional feature macro: PFA_CTRL_STATS_EN (adds stat_ops, stat_releases, stat_credit_stalls).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_last         per-lane fragment valid / last-for-this-particle
//   in_frc, in_node_id       per-lane packets {force, pid, cell} and destination node
//   in_ready                 one-hot acceptance, only for the lane granted in RUN
//   flush_req, flush_done    release every dirty lane / pulse once drained
//   credit_return            downstream consumed one released force
//   nb_frc_valid, nb_frc, node_id, nb_reg_sel, nb_reg_release_flag   registered accumulator op
module partial_force_acc_ctrl #(
    parameter int NUM_FILTERS          = 4,
    parameter int ACC_LATENCY          = 3,
    parameter int RELEASE_CREDITS      = 4,
    parameter int FORCE_WIDTH          = 32,
    parameter int PID_WIDTH            = 8,
    parameter int CELL_WIDTH           = 8,
    parameter int NODE_ID_WIDTH        = 4,
    parameter int FRC_PKT_STRUCT_WIDTH = FORCE_WIDTH + PID_WIDTH + CELL_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_FILTERS-1:0]                      in_valid,
    input  logic [NUM_FILTERS*FRC_PKT_STRUCT_WIDTH-1:0] in_frc,
    input  logic [NUM_FILTERS*NODE_ID_WIDTH-1:0]        in_node_id,
    input  logic [NUM_FILTERS-1:0]                      in_last,
    output logic [NUM_FILTERS-1:0]                      in_ready,
    input  logic                                        flush_req,
    output logic                                        flush_done,
    input  logic                                        credit_return,
    output logic                                        nb_frc_valid,
    output logic [FRC_PKT_STRUCT_WIDTH-1:0]             nb_frc,
    output logic [NODE_ID_WIDTH-1:0]                    node_id,
    output logic [NUM_FILTERS-1:0]                      nb_reg_sel,
    output logic                                        nb_reg_release_flag
`ifdef PFA_CTRL_STATS_EN
    ,
    output logic [31:0]                                 stat_ops,
    output logic [31:0]                                 stat_releases,
    output logic [31:0]                                 stat_credit_stalls
`endif
);

    localparam int CDW  = $clog2(ACC_LATENCY + 1);
    localparam int CRW  = $clog2(RELEASE_CREDITS + 1);
    localparam int PTRW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int HDRW = PID_WIDTH + CELL_WIDTH;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [CDW-1:0]           cooldown [NUM_FILTERS];
    logic [HDRW-1:0]          hdr      [NUM_FILTERS];
    logic [NODE_ID_WIDTH-1:0] hdr_node [NUM_FILTERS];
    logic [NUM_FILTERS-1:0]   dirty;
    logic [CRW-1:0]           credits;
    logic [PTRW-1:0]          ptr;

    logic [NUM_FILTERS-1:0]          cool, eligible, grant_oh;
    logic                            grant_any, grant_rel, all_cool, credit_ok, flush_done_nxt;
    logic [PTRW-1:0]                 grant_idx;
    logic [FRC_PKT_STRUCT_WIDTH-1:0] sel_frc;
    logic [NODE_ID_WIDTH-1:0]        sel_node, sel_hdr_node;
    logic [HDRW-1:0]                 sel_hdr;

    assign credit_ok = (credits != '0);
    assign all_cool  = (cool == '1);

    // Eligibility and round-robin search starting at ptr. A lane that is
    // only blocked by credits is simply not eligible, so the search moves past it.
    always_comb begin
        logic [PTRW-1:0] idx;
        cool      = '0;
        eligible  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            cool[i] = (cooldown[i] == '0);
            case (state)
                ST_RUN:   eligible[i] = in_valid[i] & cool[i] & (~in_last[i] | credit_ok);
                ST_FLUSH: eligible[i] = dirty[i] & cool[i] & credit_ok;
                default:  eligible[i] = 1'b0;
            endcase
        end
        for (int k = 0; k < NUM_FILTERS; k++) begin
            idx = PTRW'((int'(ptr) + k) % NUM_FILTERS);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        grant_oh     = '0;
        sel_frc      = '0;
        sel_node     = '0;
        sel_hdr      = '0;
        sel_hdr_node = '0;
        if (grant_any) grant_oh[grant_idx] = 1'b1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (grant_oh[i]) begin
                sel_frc      = in_frc[i*FRC_PKT_STRUCT_WIDTH +: FRC_PKT_STRUCT_WIDTH];
                sel_node     = in_node_id[i*NODE_ID_WIDTH +: NODE_ID_WIDTH];
                sel_hdr      = hdr[i];
                sel_hdr_node = hdr_node[i];
            end
        end
    end

    assign grant_rel = grant_any & ((state == ST_FLUSH) | in_last[grant_idx]);
    assign in_ready  = (state == ST_RUN) ? grant_oh : '0;

    always_comb begin
        state_nxt      = state;
        flush_done_nxt = 1'b0;
        case (state)
            ST_RUN:   if (flush_req) state_nxt = ST_FLUSH;
            ST_FLUSH: if (dirty == '0) state_nxt = ST_DRAIN;
            ST_DRAIN: if (all_cool) begin
                state_nxt      = ST_RUN;
                flush_done_nxt = 1'b1;
            end
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_RUN;
            dirty               <= '0;
            credits             <= CRW'(RELEASE_CREDITS);
            ptr                 <= '0;
            flush_done          <= 1'b0;
            nb_frc_valid        <= 1'b0;
            nb_frc              <= '0;
            node_id             <= '0;
            nb_reg_sel          <= '0;
            nb_reg_release_flag <= 1'b0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                cooldown[i] <= '0;
                hdr[i]      <= '0;
                hdr_node[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            flush_done <= flush_done_nxt;

            // A release and a returned credit in the same cycle cancel out.
            if (grant_rel && !credit_return)
                credits <= credits - 1'b1;
            else if (!grant_rel && credit_return && credits != CRW'(RELEASE_CREDITS))
                credits <= credits + 1'b1;

            if (grant_any)
                ptr <= (grant_idx == PTRW'(NUM_FILTERS - 1)) ? '0 : grant_idx + 1'b1;

            for (int i = 0; i < NUM_FILTERS; i++) begin
                if (grant_oh[i]) begin
                    cooldown[i] <= CDW'(ACC_LATENCY);
                    if (state == ST_RUN) begin
                        hdr[i]      <= sel_frc[HDRW-1:0];
                        hdr_node[i] <= sel_node;
                        dirty[i]    <= ~in_last[i];
                    end else begin
                        dirty[i]    <= 1'b0;
                    end
                end else if (cooldown[i] != '0) begin
                    cooldown[i] <= cooldown[i] - 1'b1;
                end
            end

            nb_reg_sel          <= grant_oh;
            nb_reg_release_flag <= grant_rel;
            if (grant_any && state == ST_RUN) begin
                nb_frc_valid <= 1'b1;
                nb_frc       <= sel_frc;
                node_id      <= sel_node;
            end else if (grant_any) begin
                // Flush op: release-only, force field zero, header from the lane's last fragment.
                nb_frc_valid <= 1'b0;
                nb_frc       <= {{FORCE_WIDTH{1'b0}}, sel_hdr};
                node_id      <= sel_hdr_node;
            end else begin
                nb_frc_valid <= 1'b0;
                nb_frc       <= '0;
                node_id      <= '0;
            end
        end
    end

`ifdef PFA_CTRL_STATS_EN
    logic credit_stall;
    assign credit_stall = (state == ST_RUN) && (in_valid != '0) && !grant_any && !credit_ok &&
                          ((in_valid & cool & in_last) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_ops           <= '0;
            stat_releases      <= '0;
            stat_credit_stalls <= '0;
        end else begin
            stat_ops           <= stat_ops + {31'b0, grant_any};
            stat_releases      <= stat_releases + {31'b0, grant_rel};
            stat_credit_stalls <= stat_credit_stalls + {31'b0, credit_stall};
        end
    end
`endif

endmodule
